msdap_out_serializer: RTL and testbench

- Consumer end of the ALU result path: captures each 40-bit accumulator word strobed by the ALU's output_en and transmits it MSB-first on a single serial output line.
- Generates a one-cycle frame marker on the first bit of each word and an out_ready window covering every transmitted bit.
- A small FIFO absorbs results that arrive while a word is still shifting out.
- Sits between the ALU and the chip's serial output pin.

---
 rtl/msdap_out_serializer.sv | 198 +++++++++++++++++++
 tb/tb_msdap_out_serializer.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msdap_out_serializer.sv
// -----------------------------------------------------------------------------
// msdap_out_serializer
//
// Purpose:
//   Takes the 40-bit accumulator words that the ALU strobes out and sends each
//   one MSB-first on a single serial line. Words that arrive while a frame is
//   still shifting out wait in a small FIFO. When the FIFO holds a word at the
//   end of a frame, that word is loaded with no gap cycle in between.
//
// Parameters:
//   WIDTH  bits per result word and per serial frame (default 40)
//   DEPTH  holding FIFO entries, 1..4 (default 2)
//
// Ports:
//   clk           system clock (SCLK); all logic uses the rising edge
//   clear_n       synchronous active-low reset
//   result_valid  one-cycle strobe from the ALU output_en
//   result_data   word captured when result_valid=1
//   tx_en         shift enable; when low, the serializer freezes
//   overflow_clr  clears the sticky overflow flag
//   sdo           serial data out
//   frame         high while a word's MSB is on sdo
//   out_ready     high on every cycle in which sdo carries a valid bit
//   busy          shifter active or FIFO non-empty
//   fifo_count    number of FIFO entries occupied
//   overflow      sticky; set when an incoming word is dropped
//
// Optional feature:
//   MSDAP_SER_PARITY_EN  When this macro is defined, one extra cycle follows
//                        bit 0 and carries the even parity (XOR of all WIDTH
//                        bits) of the word. Each frame is then WIDTH+1 cycles.
// -----------------------------------------------------------------------------
module msdap_out_serializer #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             result_valid,
  input  logic [WIDTH-1:0] result_data,
  input  logic             tx_en,
  input  logic             overflow_clr,
  output logic             sdo,
  output logic             frame,
  output logic             out_ready,
  output logic             busy,
  output logic [2:0]       fifo_count,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
`ifdef MSDAP_SER_PARITY_EN
  localparam logic [CNT_W-1:0] PARITY_SLOT = CNT_W'(WIDTH);
`endif

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             frame_q, frame_d;
  logic             out_ready_q, out_ready_d;
`ifdef MSDAP_SER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0]       count_q;
  logic             overflow_q;

  logic             fifo_empty, fifo_full;
  logic             load, pop, push, drop;
  logic [WIDTH-1:0] head;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_empty = (count_q == 3'd0);
  assign fifo_full  = (count_q == 3'(DEPTH));
  assign head       = mem_q[rd_ptr_q];

  // A pop on this edge frees a slot, so a full FIFO still accepts the push.
  assign push = result_valid && (!fifo_full || pop);
  assign drop = result_valid && fifo_full && !pop;

  // Next-state logic. When tx_en is low, every register holds its value.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    frame_d     = frame_q;
    out_ready_d = out_ready_q;
`ifdef MSDAP_SER_PARITY_EN
    parity_d    = parity_q;
`endif
    load        = 1'b0;

    if (tx_en) begin
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) load = 1'b1;
        end
        SHIFT: begin
          if (bit_cnt_q < LAST_BIT) begin
            shreg_d     = {shreg_q[WIDTH-2:0], 1'b0};
            bit_cnt_d   = bit_cnt_q + CNT_W'(1);
            frame_d     = 1'b0;
            out_ready_d = 1'b1;
          end
`ifdef MSDAP_SER_PARITY_EN
          else if (bit_cnt_q == LAST_BIT) begin
            // The parity bit rides in the MSB so that sdo always comes
            // straight from the shift register.
            shreg_d     = {parity_q, {(WIDTH-1){1'b0}}};
            bit_cnt_d   = PARITY_SLOT;
            frame_d     = 1'b0;
            out_ready_d = 1'b1;
          end
`endif
          else if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            // Clear the shifter so that sdo idles low.
            state_d     = IDLE;
            shreg_d     = '0;
            bit_cnt_d   = '0;
            frame_d     = 1'b0;
            out_ready_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (load) begin
      state_d     = SHIFT;
      shreg_d     = head;
      bit_cnt_d   = '0;
      frame_d     = 1'b1;
      out_ready_d = 1'b1;
`ifdef MSDAP_SER_PARITY_EN
      parity_d    = ^head;
`endif
    end
  end

  assign pop = load;

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      frame_q     <= 1'b0;
      out_ready_q <= 1'b0;
`ifdef MSDAP_SER_PARITY_EN
      parity_q    <= 1'b0;
`endif
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= 3'd0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_q     <= frame_d;
      out_ready_q <= out_ready_d;
`ifdef MSDAP_SER_PARITY_EN
      parity_q    <= parity_d;
`endif
      if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      count_q <= count_q + {2'b00, push} - {2'b00, pop};
      // When a drop and a clear request land on the same edge, the drop wins.
      if (drop)              overflow_q <= 1'b1;
      else if (overflow_clr) overflow_q <= 1'b0;
    end
  end

  // The storage has no reset. The pointers and count alone define which
  // entries are live.
  always_ff @(posedge clk) begin
    if (clear_n && push) mem_q[wr_ptr_q] <= result_data;
  end

  assign sdo        = shreg_q[WIDTH-1];
  assign frame      = frame_q;
  assign out_ready  = out_ready_q;
  assign busy       = (state_q == SHIFT) || (count_q != 3'd0);
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_msdap_out_serializer.sv
`timescale 1ns/1ps
module tb_msdap_out_serializer;

  localparam int W = 40;
  localparam int D = 2;
`ifdef MSDAP_SER_PARITY_EN
  localparam int FLEN = W + 1;
`else
  localparam int FLEN = W;
`endif

  logic         clk = 1'b0;
  logic         clear_n = 1'b0;
  logic         result_valid = 1'b0;
  logic [W-1:0] result_data = '0;
  logic         tx_en = 1'b0;
  logic         overflow_clr = 1'b0;
  logic         sdo, frame, out_ready, busy, overflow;
  logic [2:0]   fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the words that should come out, in order.
  logic [W-1:0] model_words[$];
  logic         exp_bits[$];
  // Bits observed on the line. Only enabled (advancing) cycles are recorded.
  logic         obs_bits[$];
  logic         obs_frame[$];
  logic         en_at_edge;

  always #5 clk = ~clk;

  msdap_out_serializer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk          (clk),
    .clear_n      (clear_n),
    .result_valid (result_valid),
    .result_data  (result_data),
    .tx_en        (tx_en),
    .overflow_clr (overflow_clr),
    .sdo          (sdo),
    .frame        (frame),
    .out_ready    (out_ready),
    .busy         (busy),
    .fifo_count   (fifo_count),
    .overflow     (overflow)
  );

  always @(posedge clk) en_at_edge <= tx_en;

  always @(negedge clk) begin
    if (out_ready === 1'b1 && en_at_edge === 1'b1) begin
      obs_bits.push_back(sdo);
      obs_frame.push_back(frame);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [W-1:0] w);
    result_valid = 1'b1;
    result_data  = w;
    step();
    result_valid = 1'b0;
  endtask

  task automatic start_stream();
    model_words.delete();
    obs_bits.delete();
    obs_frame.delete();
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    return W'({$urandom(), $urandom()});
  endfunction

  // Expected line content: each word MSB-first, then its parity when parity is enabled.
  function automatic void build_expected();
    exp_bits.delete();
    foreach (model_words[j]) begin
      for (int b = W - 1; b >= 0; b--) exp_bits.push_back(model_words[j][b]);
`ifdef MSDAP_SER_PARITY_EN
      exp_bits.push_back(^model_words[j]);
`endif
    end
  endfunction

  // Count bit errors and frame-marker errors. The marker belongs on every FLEN-th bit.
  function automatic int stream_errors();
    int   e = 0;
    logic fexp;
    for (int i = 0; i < exp_bits.size() && i < obs_bits.size(); i++) begin
      fexp = ((i % FLEN) == 0);
      if (obs_bits[i] !== exp_bits[i]) e++;
      if (obs_frame[i] !== fexp) e++;
    end
    return e;
  endfunction

  task automatic test_reset();
    clear_n = 1'b0; tx_en = 1'b0; result_valid = 1'b0; overflow_clr = 1'b0;
    step(); step();
    n_checks++;
    if ({sdo, frame, out_ready, busy, overflow} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: sdo/frame/out_ready/busy/overflow=%b want 00000",
               {sdo, frame, out_ready, busy, overflow});
    end
    n_checks++;
    if (fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_fifo_count: got %0d want 0", fifo_count);
    end
    clear_n = 1'b1; tx_en = 1'b1;
    step();
    $display("test_reset done");
  endtask

  task automatic test_single_word();
    bit ok;
    int e;
    start_stream();
    model_words.push_back(40'h80_0000_0001);
    push_word(40'h80_0000_0001);
    n_checks++;
    if (out_ready !== 1'b0 || fifo_count !== 3'd1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_queued: out_ready=%b fifo_count=%0d busy=%b want 0 1 1",
               out_ready, fifo_count, busy);
    end
    step();
    n_checks++;
    if (frame !== 1'b1 || sdo !== 1'b1 || out_ready !== 1'b1 || fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL single_msb: frame=%b sdo=%b out_ready=%b fifo_count=%0d want 1 1 1 0",
               frame, sdo, out_ready, fifo_count);
    end
    wait_idle(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL single_idle: busy still %b after timeout, want 0", busy);
    end
    build_expected();
    e = stream_errors();
    n_checks++;
    if (e != 0 || obs_bits.size() != exp_bits.size()) begin
      n_fail++;
      $display("FAIL single_stream: %0d bits with %0d errors, want %0d bits and 0 errors",
               obs_bits.size(), e, exp_bits.size());
    end
    $display("test_single_word: %0d bits observed", obs_bits.size());
  endtask

  task automatic test_back_to_back();
    bit ok;
    int run = 0;
    int e;
    start_stream();
    model_words.push_back(40'hFF_FFFF_FFFF);
    model_words.push_back(40'h00_0000_0000);
    push_word(40'hFF_FFFF_FFFF);
    for (int k = 1; k < 400; k++) begin
      if (k == 5) begin
        result_valid = 1'b1;
        result_data  = 40'h00_0000_0000;
      end
      step();
      result_valid = 1'b0;
      if (out_ready === 1'b1) run++;
      else if (run > 0) break;
    end
    n_checks++;
    if (run != 2 * FLEN) begin
      n_fail++;
      $display("FAIL b2b_contiguous: out_ready run=%0d want %0d", run, 2 * FLEN);
    end
    wait_idle(ok);
    build_expected();
    e = stream_errors();
    n_checks++;
    if (!ok || e != 0 || obs_bits.size() != exp_bits.size()) begin
      n_fail++;
      $display("FAIL b2b_stream: idle=%0b %0d bits with %0d errors, want 1 %0d bits 0 errors",
               ok, obs_bits.size(), e, exp_bits.size());
    end
    $display("test_back_to_back: run=%0d", run);
  endtask

  task automatic test_random_stream();
    bit           ok;
    int           e;
    logic [W-1:0] w;
    start_stream();
    for (int n = 0; n < 6; n++) begin
      w = rand_word();
      model_words.push_back(w);
      push_word(w);
      for (int g = $urandom_range(W + 12, W + 2); g > 1; g--) step();
    end
    wait_idle(ok);
    build_expected();
    e = stream_errors();
    n_checks++;
    if (!ok || e != 0 || obs_bits.size() != exp_bits.size()) begin
      n_fail++;
      $display("FAIL random_stream: idle=%0b %0d bits with %0d errors, want 1 %0d bits 0 errors",
               ok, obs_bits.size(), e, exp_bits.size());
    end
    $display("test_random_stream: %0d words, %0d bits", model_words.size(), obs_bits.size());
  endtask

  task automatic test_random_stall();
    bit           ok;
    int           e;
    logic [W-1:0] w;
    start_stream();
    for (int r = 0; r < 3; r++) begin
      for (int n = 0; n < 2; n++) begin
        w = rand_word();
        model_words.push_back(w);
        tx_en = ($urandom_range(3, 0) != 0);
        push_word(w);
        for (int g = $urandom_range(3, 1); g > 1; g--) begin
          tx_en = ($urandom_range(3, 0) != 0);
          step();
        end
      end
      for (int i = 0; i < 1000 && busy !== 1'b0; i++) begin
        tx_en = ($urandom_range(3, 0) != 0);
        step();
      end
      tx_en = 1'b1;
      step();
    end
    wait_idle(ok);
    build_expected();
    e = stream_errors();
    n_checks++;
    if (!ok || e != 0 || obs_bits.size() != exp_bits.size()) begin
      n_fail++;
      $display("FAIL stall_random_stream: idle=%0b %0d bits with %0d errors, want 1 %0d bits 0 errors",
               ok, obs_bits.size(), e, exp_bits.size());
    end
    $display("test_random_stall: %0d bits", obs_bits.size());
  endtask

  task automatic test_stall();
    bit           ok;
    int           e;
    logic [W-1:0] w;
    w = 40'hA5_A5A5_A5A5;
    start_stream();
    model_words.push_back(w);
    push_word(w);
    for (int k = 1; k <= 11; k++) step();
    n_checks++;
    if (sdo !== w[W-11] || out_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_bit10: sdo=%b out_ready=%b want %b 1", sdo, out_ready, w[W-11]);
    end
    tx_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if (sdo !== w[W-11] || out_ready !== 1'b1 || frame !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold%0d: sdo=%b out_ready=%b frame=%b want %b 1 0",
                 k, sdo, out_ready, frame, w[W-11]);
      end
    end
    tx_en = 1'b1;
    step();
    n_checks++;
    if (sdo !== w[W-12] || out_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_resume: sdo=%b out_ready=%b want %b 1", sdo, out_ready, w[W-12]);
    end
    wait_idle(ok);
    build_expected();
    e = stream_errors();
    n_checks++;
    if (!ok || e != 0 || obs_bits.size() != exp_bits.size()) begin
      n_fail++;
      $display("FAIL stall_stream: idle=%0b %0d bits with %0d errors, want 1 %0d bits 0 errors",
               ok, obs_bits.size(), e, exp_bits.size());
    end
    $display("test_stall: %0d bits", obs_bits.size());
  endtask

  task automatic test_overflow();
    bit           ok;
    int           e;
    logic [W-1:0] w1, w2, w3, w4, w5, w6;
    w1 = rand_word(); w2 = rand_word(); w3 = rand_word();
    w4 = rand_word(); w5 = rand_word(); w6 = rand_word();
    start_stream();
    model_words.push_back(w1);
    model_words.push_back(w2);
    model_words.push_back(w3);
    model_words.push_back(w5);
    push_word(w1);                 // E0
    step(); step();                // E0+1 load, E0+2
    push_word(w2);                 // E0+3
    push_word(w3);                 // E0+4
    n_checks++;
    if (fifo_count !== 3'd2 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_full: fifo_count=%0d overflow=%b want 2 0", fifo_count, overflow);
    end
    push_word(w4);                 // E0+5, dropped
    n_checks++;
    if (fifo_count !== 3'd2 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_drop: fifo_count=%0d overflow=%b want 2 1", fifo_count, overflow);
    end
    for (int k = 6; k <= FLEN; k++) step();
    n_checks++;
    if (fifo_count !== 3'd2 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: fifo_count=%0d overflow=%b want 2 1", fifo_count, overflow);
    end
    push_word(w5);                 // same edge as the pop of w2
    n_checks++;
    if (fifo_count !== 3'd2 || frame !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_push_pop: fifo_count=%0d frame=%b want 2 1", fifo_count, frame);
    end
    overflow_clr = 1'b1;
    push_word(w6);                 // full with no pop: dropped, the set wins over the clear
    overflow_clr = 1'b0;
    n_checks++;
    if (overflow !== 1'b1 || fifo_count !== 3'd2) begin
      n_fail++;
      $display("FAIL ovf_priority: overflow=%b fifo_count=%0d want 1 2", overflow, fifo_count);
    end
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: overflow=%b want 0", overflow);
    end
    wait_idle(ok);
    build_expected();
    e = stream_errors();
    n_checks++;
    if (!ok || e != 0 || obs_bits.size() != exp_bits.size()) begin
      n_fail++;
      $display("FAIL ovf_stream: idle=%0b %0d bits with %0d errors, want 1 %0d bits 0 errors",
               ok, obs_bits.size(), e, exp_bits.size());
    end
    $display("test_overflow: %0d bits", obs_bits.size());
  endtask

  task automatic test_midword_reset();
    logic [W-1:0] w1, w2;
    w1 = rand_word(); w2 = rand_word();
    start_stream();
    push_word(w1);
    for (int k = 1; k <= 21; k++) begin
      if (k == 3) begin
        result_valid = 1'b1;
        result_data  = w2;
      end
      step();
      result_valid = 1'b0;
    end
    n_checks++;
    if (sdo !== w1[W-21] || out_ready !== 1'b1 || fifo_count !== 3'd1) begin
      n_fail++;
      $display("FAIL rst_bit20: sdo=%b out_ready=%b fifo_count=%0d want %b 1 1",
               sdo, out_ready, fifo_count, w1[W-21]);
    end
    clear_n = 1'b0;
    step();
    clear_n = 1'b1;
    obs_bits.delete();
    obs_frame.delete();
    n_checks++;
    if ({sdo, frame, out_ready, busy} !== 4'b0 || fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_outputs: sdo/frame/out_ready/busy=%b fifo_count=%0d want 0000 0",
               {sdo, frame, out_ready, busy}, fifo_count);
    end
    for (int k = 0; k < 60; k++) step();
    n_checks++;
    if (obs_bits.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_quiet: %0d bits emitted busy=%b want 0 0", obs_bits.size(), busy);
    end
    $display("test_midword_reset done");
  endtask

`ifdef MSDAP_SER_PARITY_EN
  task automatic test_parity();
    bit ok;
    start_stream();
    push_word(40'h00_0000_0007);
    wait_idle(ok);
    n_checks++;
    if (!ok || obs_bits.size() != W + 1 || obs_bits[obs_bits.size() - 1] !== 1'b1) begin
      n_fail++;
      $display("FAIL parity: idle=%0b %0d bits, want 1 %0d bits ending in parity 1",
               ok, obs_bits.size(), W + 1);
    end
    $display("test_parity: %0d bits", obs_bits.size());
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_random_stream();
    test_stall();
    test_random_stall();
    test_overflow();
    test_midword_reset();
`ifdef MSDAP_SER_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
